// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction-memory boot loader.
//   WORD_W / BYTES_PER_WORD : instruction word geometry (little-endian lanes)
//   BYTE_IDX_W              : width of the lane index inside a word
//   LEN_W                   : width of the length header (two bytes)
//   state_t                 : loader FSM state encoding
//   is_rx_state()           : states in which the loader accepts stream bytes
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    // The loader only takes bytes while collecting the header or word data.
    function automatic logic is_rx_state(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// ----------------------------------------------------------------------------
// byte_packer
// Assembles a little-endian instruction word from a byte stream, one lane per
// accepted byte (lane 0 = bits 7:0).
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : restart at lane 0 (start of a new program body)
//   wr_en     : a byte is accepted this cycle on din
//   din       : stream byte
//   word_full : this accepted byte completes the word
//   word_next : the word including the byte being accepted this cycle, so the
//               owner can register it on the same edge the last lane lands
// ----------------------------------------------------------------------------
module byte_packer
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [7:0]        din,
    output logic              word_full,
    output logic [WORD_W-1:0] word_next
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [BYTE_IDX_W-1:0] byte_idx_reg;
    logic [7:0]            lane_reg [BYTES_PER_WORD];

    // Power-of-two lane count: the index wraps to 0 after the last lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_reg <= '0;
        end else if (clr) begin
            byte_idx_reg <= '0;
        end else if (wr_en) begin
            byte_idx_reg <= byte_idx_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            logic lane_sel;

            assign lane_sel = wr_en && (byte_idx_reg == BYTE_IDX_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg[gi] <= '0;
                end else if (lane_sel) begin
                    lane_reg[gi] <= din;
                end
            end

            // Bypass the incoming byte into its lane for the completed word.
            assign word_next[gi*8 +: 8] = lane_sel ? din : lane_reg[gi];
        end
    endgenerate

    assign word_full = wr_en && (byte_idx_reg == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Boot-time loader: takes a length-prefixed byte stream (16-bit little-endian
// word count, then count little-endian 32-bit words), writes the words into
// instruction memory from BASE_ADDR upward and holds the CPU in reset until
// the program is complete.
//   clk, rst            : clock, asynchronous active-high reset
//   in_data/in_valid    : stream byte and its valid
//   in_ready            : byte accepted when in_valid && in_ready
//   load_req            : start a new load (only from DONE or ERR)
//   imem_we/addr/wd     : instruction memory write port, one pulse per word
//   cpu_hold            : keeps the core in reset while not DONE
//   done                : one-cycle pulse at load completion
//   err                 : sticky, header count exceeded MAX_WORDS
// ----------------------------------------------------------------------------
module imem_loader
    import riscv_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wd,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    state_t            state_reg;
    logic [LEN_W-1:0]  count_reg;
    logic [LEN_W-1:0]  word_idx_reg;

    logic              xfer;
    logic              pack_clr;
    logic              pack_wr;
    logic              word_full;
    logic [WORD_W-1:0] word_next;
    logic [LEN_W-1:0]  count_next;
    logic [ADDR_W-1:0] word_addr;

    assign in_ready   = is_rx_state(state_reg);
    assign xfer       = in_valid && in_ready;
    assign pack_clr   = xfer && (state_reg == LEN_HI);
    assign pack_wr    = xfer && (state_reg == DATA);
    // Full header value as it will be once the high byte lands.
    assign count_next = {in_data, count_reg[7:0]};
    assign word_addr  = BASE_ADDR + (ADDR_W'(word_idx_reg) << BYTE_IDX_W);

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pack_clr),
        .wr_en     (pack_wr),
        .din       (in_data),
        .word_full (word_full),
        .word_next (word_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= LEN_LO;
            count_reg    <= '0;
            word_idx_reg <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wd      <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            unique case (state_reg)
                LEN_LO: begin
                    if (xfer) begin
                        count_reg[7:0] <= in_data;
                        state_reg      <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        count_reg[15:8] <= in_data;
                        if (count_next == '0) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else if (32'(count_next) > 32'(MAX_WORDS)) begin
                            state_reg <= ERR;
                            err       <= 1'b1;
                        end else begin
                            state_reg    <= DATA;
                            word_idx_reg <= '0;
                        end
                    end
                end
                DATA: begin
                    // Registering the port here makes imem_we high exactly
                    // during the WRITE cycle.
                    if (word_full) begin
                        state_reg <= WRITE;
                        imem_we   <= 1'b1;
                        imem_addr <= word_addr;
                        imem_wd   <= word_next;
                    end
                end
                WRITE: begin
                    if (word_idx_reg == count_reg - 1'b1) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                        cpu_hold  <= 1'b0;
                    end else begin
                        word_idx_reg <= word_idx_reg + 1'b1;
                        state_reg    <= DATA;
                    end
                end
                DONE, ERR: begin
                    if (load_req) begin
                        state_reg <= LEN_LO;
                        cpu_hold  <= 1'b1;
                        err       <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= LEN_LO;
                    cpu_hold  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int          ADDR_W    = 32;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int          MAX_WORDS = 256;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              load_req;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          nwrites   = 0;
    int          done_cnt  = 0;
    logic        prev_we   = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wd   = '0;
    int          exp_words = 0;
    int          exp_out   = 0;
    int          w0        = 0;
    int          d0        = 0;
    logic [7:0]  stream_q[$];
    wr_t         exp_q[$];

    imem_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .load_req  (load_req),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wd   (imem_wd),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference: header count, then words placed at consecutive word addresses.
    // Returns 0 for a completed load, 1 for an oversize header.
    function automatic int model_load();
        int cnt;
        cnt = int'({stream_q[1], stream_q[0]});
        if (cnt == 0) return 0;
        if (cnt > MAX_WORDS) return 1;
        for (int i = 0; i < cnt; i++) begin
            wr_t e;
            e.addr = BASE_ADDR + 32'(4 * i);
            e.wd   = {stream_q[2+4*i+3], stream_q[2+4*i+2], stream_q[2+4*i+1], stream_q[2+4*i]};
            exp_q.push_back(e);
        end
        return 0;
    endfunction

    // Write-port and done monitor.
    always @(negedge clk) begin
        if (rst) begin
            prev_we   <= 1'b0;
            prev_done <= 1'b0;
        end else begin
            if (imem_we) begin
                $display("WRITE addr=%08h wd=%08h", imem_addr, imem_wd);
                check("ready_in_write", {31'b0, in_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {31'b0, imem_we}, 32'd0);
                end else begin
                    check("write_addr", imem_addr, exp_q[0].addr);
                    check("write_wd", imem_wd, exp_q[0].wd);
                    void'(exp_q.pop_front());
                end
                nwrites   <= nwrites + 1;
                last_addr <= imem_addr;
                last_wd   <= imem_wd;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                check("hold_at_done", {31'b0, cpu_hold}, 32'd0);
                check("done_single", {31'b0, prev_done}, 32'd0);
                check("done_after_write", {31'b0, prev_we}, (exp_words > 0) ? 32'd1 : 32'd0);
            end
            prev_we   <= imem_we;
            prev_done <= done;
        end
    end

    task automatic make_program(input int n);
        stream_q.delete();
        stream_q.push_back(8'(n));
        stream_q.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) stream_q.push_back(8'($urandom));
    endtask

    task automatic start_load();
        w0 = nwrites;
        d0 = done_cnt;
        exp_q.delete();
        exp_out   = model_load();
        exp_words = exp_q.size();
    endtask

    // Called and returns on a falling edge; the byte is held until accepted.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int   gap;
        logic acc;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int k = 0; k < 100; k++) begin
            acc = in_ready;
            @(negedge clk);
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) check("byte_accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic send_range(input int from, input int to, input int max_gap);
        for (int i = from; i < to; i++) send_byte(stream_q[i], max_gap);
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        #1;
    endtask

    task automatic finish_load(input string tag, input bit coincide);
        in_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done || err) break;
            @(negedge clk);
        end
        if (!(done || err)) check({tag, "_end"}, {31'b0, done}, 32'd1);
        if (coincide && done) begin
            pulse_req();
            check({tag, "_hold_req"}, {31'b0, cpu_hold}, 32'd1);
            check({tag, "_ready_req"}, {31'b0, in_ready}, 32'd1);
        end else begin
            @(negedge clk);
            #1;
            check({tag, "_hold"}, {31'b0, cpu_hold}, 32'(exp_out));
            check({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
        end
        check({tag, "_writes"}, 32'(nwrites - w0), 32'(exp_words));
        check({tag, "_dones"}, 32'(done_cnt - d0), (exp_out == 0) ? 32'd1 : 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'(exp_out));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        $display("LOAD %s words=%0d outcome=%0d", tag, exp_words, exp_out);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        load_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", {31'b0, imem_we}, 32'd0);
        check("rst_addr", imem_addr, BASE_ADDR);
        check("rst_wd", imem_wd, 32'd0);
        check("rst_hold", {31'b0, cpu_hold}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        // Two-word reference program, no gaps.
        stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
        start_load();
        send_range(0, stream_q.size(), 0);
        finish_load("plan", 1'b0);
        pulse_req();
        check("plan_req_hold", {31'b0, cpu_hold}, 32'd1);

        // Empty program.
        stream_q = '{8'h00, 8'h00};
        start_load();
        send_range(0, 2, 0);
        finish_load("empty", 1'b0);
        pulse_req();

        // Oversize header (257).
        stream_q = '{8'h01, 8'h01};
        start_load();
        send_range(0, 2, 0);
        finish_load("over", 1'b0);
        repeat (4) @(negedge clk);
        check("over_sticky", {31'b0, err}, 32'd1);
        pulse_req();
        check("over_clear_err", {31'b0, err}, 32'd0);
        check("over_clear_ready", {31'b0, in_ready}, 32'd1);
        check("over_clear_hold", {31'b0, cpu_hold}, 32'd1);

        // Random programs with random valid gaps.
        for (int r = 0; r < 4; r++) begin
            make_program((r == 0) ? 3 : int'($urandom_range(5, 1)));
            start_load();
            send_range(0, stream_q.size(), 5);
            finish_load("gaps", 1'b0);
            pulse_req();
        end

        // load_req mid-DATA is ignored; load_req with the done pulse is honoured.
        make_program(2);
        start_load();
        send_range(0, 5, 0);
        pulse_req();
        check("mid_req_ready", {31'b0, in_ready}, 32'd1);
        check("mid_req_hold", {31'b0, cpu_hold}, 32'd1);
        send_range(5, stream_q.size(), 2);
        finish_load("mid_req", 1'b1);

        // Second program overwrites from BASE_ADDR.
        make_program(2);
        start_load();
        send_range(0, stream_q.size(), 0);
        finish_load("overwrite", 1'b0);
        pulse_req();

        // Reset in the middle of the second word.
        stream_q = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                     8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        start_load();
        send_range(0, 8, 0);
        #1;
        check("partial_writes", 32'(nwrites - w0), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_we", {31'b0, imem_we}, 32'd0);
        check("arst_addr", imem_addr, BASE_ADDR);
        check("arst_wd", imem_wd, 32'd0);
        check("arst_hold", {31'b0, cpu_hold}, 32'd1);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_err", {31'b0, err}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        stream_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        start_load();
        send_range(0, stream_q.size(), 0);
        finish_load("reload", 1'b0);
        check("reload_wd", last_wd, 32'hDEAD_BEEF);
        check("reload_addr", last_addr, BASE_ADDR);
        pulse_req();

        // Largest legal program.
        make_program(MAX_WORDS);
        start_load();
        send_range(0, stream_q.size(), 0);
        finish_load("max", 1'b0);
        check("max_last_addr", last_addr, BASE_ADDR + 32'(4 * (MAX_WORDS - 1)));
        pulse_req();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader for the single-cycle RISC-V core's instruction memory.
- Receives a length-prefixed byte stream from a host link (UART receiver or testbench) over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them through the instruction memory's write port.
- Holds the CPU in reset (cpu_hold) until the program is fully loaded.

Parameters:
- ADDR_W, 32, width of the instruction memory byte address.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be word aligned.
- MAX_WORDS, 256, instruction memory capacity in words; a larger header count is an error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
- load_req  in  1  single-cycle request to start a new load; honoured only in DONE or ERR.
- imem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_W  byte address of the word being written.
- imem_wd  out  32  word being written.
- cpu_hold  out  1  high keeps the core in reset and the PC at BASE_ADDR.
- done  out  1  one-cycle pulse when a load completes.
- err  out  1  sticky flag: header count exceeded MAX_WORDS.

Behaviour:
- Reset (async, rst=1):
  - state=LEN_LO; word_idx=0; byte_idx=0; count=0.
  - imem_we=0; imem_addr=BASE_ADDR; imem_wd=0.
  - cpu_hold=1; done=0; err=0.
  - in_ready=1 after reset releases.
- All outputs are registered, except in_ready, which is decoded from state.
- in_ready is 1 in LEN_LO, LEN_HI and DATA, and 0 in WRITE, DONE and ERR.
- LEN_LO: on transfer, count[7:0]=in_data; go to LEN_HI.
- LEN_HI: on transfer, count[15:8]=in_data, then:
  - count==0: go to DONE.
  - count>MAX_WORDS: go to ERR.
  - otherwise: go to DATA with word_idx=0, byte_idx=0.
- DATA: on transfer, in_data goes into word lane byte_idx (byte 0 = bits 7:0); byte_idx increments.
  - When the transfer has byte_idx==3, go to WRITE; byte_idx wraps to 0.
  - No transfer: hold state; a partial word is retained indefinitely.
- WRITE (exactly 1 cycle):
  - imem_we=1; imem_addr=BASE_ADDR + 4*word_idx (ADDR_W-bit arithmetic); imem_wd=assembled word.
  - If word_idx==count-1, go to DONE; otherwise word_idx+1 and go to DATA.
- Cost per word: minimum 4 byte cycles plus 1 write cycle.
- imem_we is 0 in every state other than WRITE; imem_addr and imem_wd hold their last values.
- Entering DONE:
  - done=1 for exactly one cycle.
  - cpu_hold falls on the same edge and remains 0 while in DONE.
- ERR: cpu_hold stays 1; err=1 and stays set until reset or an honoured load_req; no memory writes occur.
- load_req in DONE or ERR:
  - Next state LEN_LO; cpu_hold=1 on that edge; err cleared.
  - Previously loaded memory contents are not cleared.
- load_req in any other state is ignored.
- A load_req coinciding with the done pulse cycle is honoured; done still pulses for that one cycle.
- Bytes presented while in_ready=0 are neither consumed nor dropped; the source holds them.
- Max count equal to MAX_WORDS is legal; the last address is BASE_ADDR + 4*(MAX_WORDS-1).
- Reset mid-load: the load is aborted immediately and partially written words remain in memory. The host must restart from the header.

Decomposition:
- Shared package riscv_pkg holds:
  - the state encoding constants: LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR;
  - WORD_W=32 and BYTES_PER_WORD=4.
- One natural sub-module, byte_packer: a 4-lane shift and assemble register with byte_idx counter and a word_full flag.
- The FSM, address generation and control remain in imem_loader.

Test Plan:
- Stream 02 00 | 13 00 10 00 | 93 00 20 00, in_valid held high -> imem_we pulses twice:
  - addr 0x0, wd 0x00100013;
  - addr 0x4, wd 0x00200093;
  - done pulses once the cycle after the second write; cpu_hold falls then.
- Header 00 00 -> DONE directly after the second byte, with no imem_we and one done pulse.
- Header 01 01 (257) with MAX_WORDS=256 -> err=1, cpu_hold remains 1, in_ready=0, no writes. A load_req then returns to LEN_LO with err=0.
- Bytes with random in_valid gaps of 0-5 cycles for a 3-word program -> identical writes to the gap-free case; in_ready=0 during each WRITE cycle, and no byte is lost.
- Assert rst after 6 data bytes -> all outputs return to reset values asynchronously. A reload with count 1 and bytes EF BE AD DE then writes 0xDEADBEEF to addr BASE_ADDR.
- load_req issued mid-DATA -> ignored with no state change; load_req in DONE -> cpu_hold rises next edge and a second program overwrites from BASE_ADDR.
